// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the single mem_sys access port among NREQ requesters.
// Memory-side signals are registered; read data is routed back with a one-hot rvalid.
module mem_port_arbiter #(
  parameter int NREQ   = 3,
  parameter int AW     = 17,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    we,
  input  logic [3*NREQ-1:0]  bank,
  input  logic [AW*NREQ-1:0] addr,
  input  logic [DW*NREQ-1:0] wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rvalid,
  output logic [DW-1:0]      rdata,
  output logic               err,
  output logic               read_rq_x,
  output logic               read_rq_w1,
  output logic               read_rq_w2,
  output logic               read_rq_w3,
  output logic               read_rq_w4,
  output logic               write_rq_x,
  output logic               write_rq_w1,
  output logic               write_rq_w2,
  output logic               write_rq_w3,
  output logic               write_rq_w4,
  output logic [AW-1:0]      rw_address,
  output logic [DW-1:0]      write_data,
  input  logic [DW-1:0]      read_data_x,
  input  logic [DW-1:0]      read_data_w1,
  input  logic [DW-1:0]      read_data_w2,
  input  logic [DW-1:0]      read_data_w3,
  input  logic [DW-1:0]      read_data_w4
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Handshake: a requester holds req and its we/bank/addr/wdata stable until it
  // sees gnt high; the transaction is accepted at the rising edge where gnt=1.
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic [PW-1:0] gnt_idx;
  logic          gnt_any;
  logic [NREQ-1:0] gnt_c;

  logic          sel_we;
  logic [2:0]    sel_bank;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_legal;
  logic [4:0]    bank_oh;

  logic [4:0]    rd_rq_q;
  logic [4:0]    wr_rq_q;

  // Read tracking pipeline: stage 0 is the strobe cycle, stage RD_LAT is the
  // cycle in which mem_sys presents the data.
  logic [RD_LAT:0]           pl_v;
  logic [RD_LAT:0][PW-1:0]   pl_idx;
  logic [RD_LAT:0][2:0]      pl_bank;
  logic [DW-1:0]             ret_data;

  always_comb begin
    int j;
    gnt_any = 1'b0;
    gnt_idx = '0;
    gnt_c   = '0;
    j       = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!gnt_any && req[j]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(j);
      end
    end
    if (!rst) begin
      gnt_any = 1'b0;
      gnt_idx = '0;
    end
    if (gnt_any) gnt_c[gnt_idx] = 1'b1;
  end

  assign gnt = gnt_c;

  always_comb begin
    int s;
    s         = int'(gnt_idx);
    sel_we    = we[s];
    sel_bank  = bank[3*s +: 3];
    sel_addr  = addr[AW*s +: AW];
    sel_wdata = wdata[DW*s +: DW];
    sel_legal = (sel_bank <= 3'd4);
    bank_oh   = 5'b00001 << sel_bank;
    ptr_nxt   = (s == NREQ - 1) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr        <= '0;
      rd_rq_q    <= '0;
      wr_rq_q    <= '0;
      err        <= 1'b0;
      rw_address <= '0;
      write_data <= '0;
    end else begin
      rd_rq_q <= '0;
      wr_rq_q <= '0;
      err     <= 1'b0;
      if (gnt_any) begin
        ptr        <= ptr_nxt;
        rw_address <= sel_addr;
        if (sel_we) write_data <= sel_wdata;
        if (!sel_legal) err <= 1'b1;
        else if (sel_we) wr_rq_q <= bank_oh;
        else rd_rq_q <= bank_oh;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pl_v    <= '0;
      pl_idx  <= '0;
      pl_bank <= '0;
    end else begin
      pl_v[0]    <= gnt_any && !sel_we;
      pl_idx[0]  <= gnt_idx;
      pl_bank[0] <= sel_bank;
      for (int k = 1; k <= RD_LAT; k++) begin
        pl_v[k]    <= pl_v[k-1];
        pl_idx[k]  <= pl_idx[k-1];
        pl_bank[k] <= pl_bank[k-1];
      end
    end
  end

  // Illegal banks return zero so the requester still gets its response.
  always_comb begin
    ret_data = '0;
    case (pl_bank[RD_LAT])
      3'd0:    ret_data = read_data_x;
      3'd1:    ret_data = read_data_w1;
      3'd2:    ret_data = read_data_w2;
      3'd3:    ret_data = read_data_w3;
      3'd4:    ret_data = read_data_w4;
      default: ret_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid <= '0;
      rdata  <= '0;
    end else begin
      rvalid <= '0;
      if (pl_v[RD_LAT]) begin
        rvalid <= NREQ'(1) << pl_idx[RD_LAT];
        rdata  <= ret_data;
      end
    end
  end

  assign read_rq_x   = rd_rq_q[0];
  assign read_rq_w1  = rd_rq_q[1];
  assign read_rq_w2  = rd_rq_q[2];
  assign read_rq_w3  = rd_rq_q[3];
  assign read_rq_w4  = rd_rq_q[4];
  assign write_rq_x  = wr_rq_q[0];
  assign write_rq_w1 = wr_rq_q[1];
  assign write_rq_w2 = wr_rq_q[2];
  assign write_rq_w3 = wr_rq_q[3];
  assign write_rq_w4 = wr_rq_q[4];

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Round-robin arbiter sharing the single mem_sys access port (rw_address, write_data, one read/write strobe pair per bank x, w1..w4) among NREQ requesters, e.g. input loader, PE-array weight fetch and result writer.
- Issues at most one memory transaction per cycle and registers all memory-side signals.
- Routes the selected bank's read data back to the originating requester with a one-hot valid.

Parameters:
- NREQ, 3, number of requesters (2..8)
- AW, 17, address width
- DW, 8, data width
- RD_LAT, 1, cycles from a registered read strobe being high to valid read_data_* from mem_sys (1..4)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- req  in  NREQ  per-requester transaction request, held until granted
- we  in  NREQ  1=write, 0=read, per requester
- bank  in  3*NREQ  per-requester bank: 0=x, 1=w1, 2=w2, 3=w3, 4=w4, 5..7 illegal
- addr  in  AW*NREQ  per-requester address
- wdata  in  DW*NREQ  per-requester write data
- gnt  out  NREQ  one-hot, combinational; request accepted at this rising edge
- rvalid  out  NREQ  one-hot, registered; rdata belongs to that requester
- rdata  out  DW  registered read data
- err  out  1  registered one-cycle pulse, illegal bank accepted
- read_rq_x, read_rq_w1..read_rq_w4  out  1 each  registered read strobes to mem_sys
- write_rq_x, write_rq_w1..write_rq_w4  out  1 each  registered write strobes to mem_sys
- rw_address  out  AW  registered shared address
- write_data  out  DW  registered shared write data
- read_data_x, read_data_w1..read_data_w4  in  DW each  mem_sys read data

Behaviour:
- Reset (rst low, async): all ten strobes 0, rw_address 0, write_data 0, rvalid 0, rdata 0, err 0, priority pointer ptr=0, in-flight pipeline cleared. gnt is forced 0 while rst is low.
- Arbitration is combinational each cycle. Starting at index ptr and wrapping modulo NREQ, the first i with req[i]=1 gets gnt[i]=1; all other gnt bits are 0. If no requests, gnt=0.
- On a clock edge with a grant to i:
  - ptr <= (i+1) mod NREQ.
  - Next cycle: rw_address=addr[i]. write_data=wdata[i] for writes, otherwise it holds its previous value.
  - Exactly one strobe high, selected by bank[i] and we[i].
- With no grant: all strobes 0 next cycle, ptr unchanged, rw_address and write_data hold.
- Strobes are single-cycle pulses per transaction. Back-to-back grants produce strobes on consecutive cycles, sustaining 1 transaction/cycle.
- Illegal bank (5..7): the request is still granted and ptr still advances. No strobe is issued; err pulses high in the strobe cycle.
  - An illegal read still returns rvalid[i] at the normal time with rdata=0.
  - An illegal write produces no further effect.
- Read return: the requester index and bank are tracked through an RD_LAT-deep shift pipeline.
  - If the strobe is high in cycle T, then at edge T+RD_LAT the arbiter samples the matching read_data_<bank>.
  - That value drives rdata, and rvalid[i]=1, during cycle T+RD_LAT+1.
  - Total latency from the grant edge to rvalid = RD_LAT+1 cycles.
  - rvalid is a one-cycle pulse; rdata holds its last value otherwise.
- Writes produce no rvalid.
- Ordering: responses return in grant order. Reads and writes to the same address in consecutive grants are executed in grant order. No hazard checking beyond mem_sys's own behaviour.
- Requester rules: keep req, we, bank, addr and wdata stable until gnt is seen. After gnt, the requester may deassert req or present a new transaction in the next cycle.
- Reset mid-operation: in-flight reads are discarded with no rvalid, and strobes drop immediately.

Test Plan:
- Reset then idle: rst low 50 ns -> all strobes 0, rw_address=0, gnt=0, rvalid=0. After release with req=0 for 10 cycles -> no strobes.
- Single requester writes then reads:
  - req1 writes bank=2 (w2), addr 1..8, wdata 10..17 -> write_rq_w2 pulses 8 cycles with matching rw_address/write_data.
  - Then req1 reads addr 5 -> read_rq_w2 one cycle, rvalid=3'b010 with rdata=14 RD_LAT+1 cycles after the grant.
- Round-robin fairness: all three req held high continuously with reads to distinct banks -> gnt sequence 001, 010, 100, 001, ... and rvalid returns in the same order.
- Pointer skip: req0 and req2 high, req1 low, ptr=1 -> gnt=100 first, then 001, then 100.
- Illegal bank: req0 read bank=6 -> gnt=001, no strobe, err pulse, rvalid=001 with rdata=0.
- Reset mid-read: grant a read, then assert rst before the rvalid cycle -> no rvalid, all outputs reset. After release, a new read to x addr 3 completes normally.
